// File: rtl/sdf_stage_ctrl.sv
// Control FSM for one radix-2 single-path delay-feedback FFT stage: delay-line shift
// enable, butterfly select, twiddle index, output qualification and frame-boundary flushing.
module sdf_stage_ctrl #(
    parameter int  DELAY = 8,
    parameter int  NPT   = 32,
    localparam int CW    = $clog2(2 * DELAY)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic          sr_en,
    output logic          sel,
    output logic [4:0]    tw_idx,
    output logic          out_valid,
    output logic          frame_done,
    output logic          busy,
    output logic [1:0]    o_dbg_state,
    output logic [CW-1:0] o_dbg_cnt,
    output logic          o_dbg_flush_pend
);

    localparam int FW = CW - 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DELAY - 1);
    localparam logic [FW-1:0] FILL_LAST  = FW'(DELAY - 1);
    localparam logic [4:0]    TW_STRIDE  = 5'(NPT / (2 * DELAY));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [FW-1:0] r_fill_cnt;
    logic [FW-1:0] w_fill_nxt;
    logic          r_flush_pend;
    logic          w_pend_nxt;
    logic          w_consume;
    logic          w_cnt_zero;
    logic          w_flush_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_fill_cnt   <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_fill_cnt   <= w_fill_nxt;
            r_flush_pend <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fill_nxt  = r_fill_cnt;
        w_pend_nxt  = r_flush_pend;
        w_cnt_zero  = (r_cnt == '0);
        w_flush_req = flush | r_flush_pend;
        in_ready    = 1'b1;
        w_consume   = 1'b0;
        sel         = 1'b0;
        sr_en       = 1'b0;
        out_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_consume = in_valid;
                sel       = r_cnt[CW-1];
                sr_en     = w_consume;
                if (w_consume) begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_fill_nxt  = r_fill_cnt + FW'(1);
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                in_ready  = !(w_cnt_zero && w_flush_req);
                w_consume = in_valid & in_ready;
                sel       = r_cnt[CW-1];
                sr_en     = w_consume;
                // A flush seen while filling is only remembered; it takes effect at a RUN frame boundary.
                if (flush && !w_cnt_zero) begin
                    w_pend_nxt = 1'b1;
                end
                if (w_consume) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_fill_cnt == FILL_LAST) begin
                        w_fill_nxt  = '0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_fill_nxt = r_fill_cnt + FW'(1);
                    end
                end
            end
            S_RUN: begin
                in_ready  = !(w_cnt_zero && w_flush_req);
                w_consume = in_valid & in_ready;
                sel       = r_cnt[CW-1];
                sr_en     = w_consume;
                out_valid = w_consume;
                if (flush && !w_cnt_zero) begin
                    w_pend_nxt = 1'b1;
                end
                if (w_cnt_zero && w_flush_req) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_consume) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                in_ready  = 1'b0;
                sr_en     = 1'b1;
                out_valid = 1'b1;
                if (r_cnt == DRAIN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_fill_nxt  = '0;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign frame_done       = w_consume && (r_cnt == CNT_LAST);
    assign tw_idx           = sel ? (5'(r_cnt[CW-2:0]) * TW_STRIDE) : 5'd0;
    assign busy             = (r_state != S_IDLE);
    assign o_dbg_state      = r_state;
    assign o_dbg_cnt        = r_cnt;
    assign o_dbg_flush_pend = r_flush_pend;

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 Parameter DELAY, default 8: length of the controlled delay line; SHALL be a power of 2 in 2..16.
REQ-002 Parameter NPT, default 32: FFT size; the derived stride TW_STRIDE = NPT/(2*DELAY).
REQ-003 Derived CW = log2(2*DELAY): sample-counter width.
REQ-004 clk  in  1  rising-edge clock; one clock only.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream sample present.
REQ-007 in_ready  out  1  controller accepts the sample; consume = in_valid & in_ready.
REQ-008 flush  in  1  request to drain the delay line at the next frame boundary.
REQ-009 sr_en  out  1  shift enable for the delay line.
REQ-010 sel  out  1  0 = pass/fill (input to delay line, delay output to stage output); 1 = butterfly (sum out, difference into delay line).
REQ-011 tw_idx  out  5  twiddle ROM index for the stage output.
REQ-012 out_valid  out  1  stage output is meaningful this cycle.
REQ-013 frame_done  out  1  last sample of a 2*DELAY frame consumed this cycle.
REQ-014 busy  out  1  state is not IDLE.

Function
REQ-015 States SHALL be IDLE, FILL, RUN, DRAIN, plus a CW-bit counter cnt, a fill counter, and a flush_pend flag.
REQ-016 All outputs SHALL be combinational from the registered state, cnt and flush_pend, plus the in_valid and flush inputs; there is no added latency.
REQ-017 in_ready: 1 in IDLE; 0 in DRAIN; in FILL/RUN, 0 when cnt==0 and (flush|flush_pend), else 1.
REQ-018 On consume, cnt SHALL increment modulo 2*DELAY; in DRAIN, cnt SHALL increment every cycle.
REQ-019 sel = cnt[CW-1] in FILL/RUN (and in the IDLE consume cycle, where cnt==0); sel = 0 in DRAIN.
REQ-020 sr_en = consume in IDLE/FILL/RUN; sr_en = 1 in DRAIN.
REQ-021 tw_idx = cnt[CW-2:0]*TW_STRIDE when sel==1, else 0; the product SHALL fit in 5 bits for all legal parameters.
REQ-022 IDLE + in_valid: the sample is consumed as frame sample 0, and the next state is FILL.
REQ-023 out_valid = 0 for the first DELAY consumed samples after leaving IDLE (FILL); FILL->RUN occurs on the DELAY-th consume.
REQ-024 out_valid = consume in RUN, and 1 in DRAIN.
REQ-025 frame_done = consume & (cnt == 2*DELAY-1); wrap-around to 0 happens on the same edge.
REQ-026 flush in FILL/RUN with cnt != 0 SHALL set flush_pend; it is held until acted upon.
REQ-027 In RUN with cnt==0 and (flush|flush_pend): no consume occurs that cycle, and the next state is DRAIN.
REQ-028 A pending flush reached while still in FILL SHALL be deferred until RUN reaches cnt==0.
REQ-029 DRAIN lasts exactly DELAY cycles (cnt 0..DELAY-1), then goes to IDLE with cnt=0 and flush_pend=0.
REQ-030 flush in IDLE or DRAIN SHALL be ignored; in_valid in DRAIN is not consumed.
REQ-031 Simultaneous flush and a consume of the frame's last sample: the wrap to cnt=0 occurs, flush_pend is set, and DRAIN is entered on the following edge.

Reset
REQ-032 rst at any edge, including mid-FILL, mid-RUN or mid-DRAIN, SHALL force IDLE, cnt=0, fill counter=0, flush_pend=0.
REQ-033 While in IDLE with in_valid=0 and flush=0, outputs SHALL be sr_en=0, sel=0, tw_idx=0, out_valid=0, frame_done=0, busy=0, in_ready=1.

Verification (DELAY=8, NPT=32)
REQ-034 in_valid=1 for 32 cycles from IDLE:
- out_valid=0 on cycles 0-7 and 1 on cycles 8-31.
- sel=1 on cycles 8-15 and 24-31.
- frame_done on cycles 15 and 31.
REQ-035 Same stream: tw_idx = 0,2,4,...,14 during every sel=1 run, and 0 elsewhere.
REQ-036 in_valid alternating 1/0 for 32 cycles:
- sr_en mirrors in_valid.
- cnt advances only on consume.
- frame_done occurs on the 16th consume.
REQ-037 flush pulse at cnt=5 in RUN:
- flush_pend is set.
- At cnt==0, in_ready=0.
- Then 8 DRAIN cycles with sr_en=1, out_valid=1, sel=0.
- Then IDLE with busy=0.
REQ-038 rst=1 on DRAIN cycle 3: the next cycle is IDLE with all REQ-033 values; in_valid then restarts FILL with out_valid=0 for 8 consumes.
REQ-039 in_valid=1 held through DRAIN: no consume, in_ready=0 for all 8 DRAIN cycles, and the sample is consumed first in IDLE.
